// File: rtl/cmos_pkg.sv
// Shared definitions for the CMOS capture sequencer and its line meter.
// Holds the capture FSM state encoding and the default 1280x720 sensor mode geometry.
// No ports; imported by the interface, the line meter and the top level.
package cmos_pkg;

  // Capture sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_ARM     = 2'd2,
    ST_CAPTURE = 2'd3
  } cap_state_e;

  // Default sensor mode: 1280 bytes (640 packed words) per line, 720 lines
  localparam int DEF_EXP_BYTES   = 1280;
  localparam int DEF_EXP_LINES   = 720;
  localparam int DEF_CNT_W       = 12;
  localparam int DEF_SKIP_FRAMES = 10;

  // Anything other than IDLE counts as busy towards the host
  function automatic logic state_busy(input cap_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/cmos_capture_ctrl_if.sv
// Sensor/host/packer bundle of the capture sequencer.
// Ports: sensor side (vsync_i, de_i, pdata_i), host side (cap_start, cap_cont, cap_abort,
// busy, size_err, line_cnt, last_bytes, frame_start, frame_done), packer side (de_o, pdata_o).
interface cmos_capture_ctrl_if #(
  parameter int CNT_W = cmos_pkg::DEF_CNT_W
);

  // Sensor side
  logic             vsync_i;
  logic             de_i;
  logic [7:0]       pdata_i;
  // Host requests
  logic             cap_start;
  logic             cap_cont;
  logic             cap_abort;
  // Packer side
  logic             de_o;
  logic [7:0]       pdata_o;
  // Host status
  logic             frame_start;
  logic             frame_done;
  logic             busy;
  logic             size_err;
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] last_bytes;

  // Environment view: drives sensor and host requests, observes everything else
  modport master (
    output vsync_i, de_i, pdata_i, cap_start, cap_cont, cap_abort,
    input  de_o, pdata_o, frame_start, frame_done, busy, size_err, line_cnt, last_bytes
  );

  // Capture controller view
  modport slave (
    input  vsync_i, de_i, pdata_i, cap_start, cap_cont, cap_abort,
    output de_o, pdata_o, frame_start, frame_done, busy, size_err, line_cnt, last_bytes
  );

endinterface

// File: rtl/cmos_line_meter.sv
// Edge detection, whole-line gating and frame measurement for the capture sequencer.
// Latency: de_o/pdata_o are 1 cycle behind de_i/pdata_i; edges act in the cycle they are seen.
// Ports: sensor in (vsync_i, de_i, pdata_i), control in (cap_en_i, frame_clr_i, err_clr_i),
// edges out (vs_rise_o, vs_fall_o), packer out (de_o, pdata_o), status out (size_err_o,
// line_cnt_o, last_bytes_o).
module cmos_line_meter
  import cmos_pkg::*;
#(
  parameter int EXP_BYTES = DEF_EXP_BYTES,
  parameter int EXP_LINES = DEF_EXP_LINES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vsync_i,
  input  logic             de_i,
  input  logic [7:0]       pdata_i,
  input  logic             cap_en_i,     // in CAPTURE and not being aborted
  input  logic             frame_clr_i,  // entering CAPTURE: restart byte and line counting
  input  logic             err_clr_i,    // accepted cap_start: clear the sticky error
  output logic             vs_rise_o,
  output logic             vs_fall_o,
  output logic             de_o,
  output logic [7:0]       pdata_o,
  output logic             size_err_o,
  output logic [CNT_W-1:0] line_cnt_o,
  output logic [CNT_W-1:0] last_bytes_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_B   = CNT_W'(EXP_BYTES);
  localparam logic [CNT_W-1:0] EXP_L   = CNT_W'(EXP_LINES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic             vs_q, de_q;
  logic             line_ok_q, line_ok_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] line_acc_q, line_acc_d;
  logic [CNT_W-1:0] last_bytes_q, last_bytes_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic             size_err_q, size_err_d;
  logic             de_o_q;
  logic [7:0]       pdata_o_q;

  logic             vs_rise, vs_fall, de_rise, de_fall;
  logic             line_open, line_close, frame_end, fwd;
  logic [CNT_W-1:0] lines_fin;
  logic             byte_bad, lines_bad;

  always_comb begin
    vs_rise    = vsync_i & ~vs_q;
    vs_fall    = ~vsync_i & vs_q;
    de_rise    = de_i & ~de_q;
    de_fall    = ~de_i & de_q;
    // A line only opens on a real de rising edge, so a line already running when
    // CAPTURE starts never sets line_ok and is dropped as a whole.
    line_open  = cap_en_i & de_rise & ~vs_rise;
    // vs_rise with a line still open truncates it; it is measured like a normal line end.
    line_close = cap_en_i & line_ok_q & (de_fall | vs_rise);
    frame_end  = cap_en_i & vs_rise;
    // The byte on the vs_rise cycle already belongs to blanking and is not forwarded.
    fwd        = cap_en_i & de_i & ~vs_rise & (line_ok_q | de_rise);
    // Frame-end line total includes a line being closed in the very same cycle
    lines_fin  = line_close ? sat_inc(line_acc_q) : line_acc_q;
    // A saturated counter no longer represents the true count, so it is always a mismatch
    byte_bad   = (byte_cnt_q != EXP_B) | (byte_cnt_q == CNT_MAX);
    lines_bad  = (lines_fin != EXP_L) | (lines_fin == CNT_MAX);
  end

  always_comb begin
    line_ok_d    = line_ok_q;
    byte_cnt_d   = byte_cnt_q;
    line_acc_d   = line_acc_q;
    last_bytes_d = last_bytes_q;
    line_cnt_d   = line_cnt_q;
    size_err_d   = size_err_q;

    if (!cap_en_i || line_close) begin
      line_ok_d = 1'b0;
    end else if (line_open) begin
      line_ok_d = 1'b1;
    end

    // The opening byte is itself forwarded, so the count restarts at 1
    if (frame_clr_i) begin
      byte_cnt_d = '0;
    end else if (line_open) begin
      byte_cnt_d = CNT_W'(1);
    end else if (fwd) begin
      byte_cnt_d = sat_inc(byte_cnt_q);
    end

    if (frame_clr_i) begin
      line_acc_d = '0;
    end else if (line_close) begin
      line_acc_d = sat_inc(line_acc_q);
    end

    if (line_close) begin
      last_bytes_d = byte_cnt_q;
    end

    if (frame_end) begin
      line_cnt_d = lines_fin;
    end

    if (err_clr_i) begin
      size_err_d = 1'b0;
    end else if ((line_close && byte_bad) || (frame_end && lines_bad)) begin
      size_err_d = 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      line_ok_q    <= 1'b0;
      byte_cnt_q   <= '0;
      line_acc_q   <= '0;
      last_bytes_q <= '0;
      line_cnt_q   <= '0;
      size_err_q   <= 1'b0;
      de_o_q       <= 1'b0;
      pdata_o_q    <= '0;
    end else begin
      vs_q         <= vsync_i;
      de_q         <= de_i;
      line_ok_q    <= line_ok_d;
      byte_cnt_q   <= byte_cnt_d;
      line_acc_q   <= line_acc_d;
      last_bytes_q <= last_bytes_d;
      line_cnt_q   <= line_cnt_d;
      size_err_q   <= size_err_d;
      de_o_q       <= fwd;
      pdata_o_q    <= pdata_i;
    end
  end

  assign vs_rise_o    = vs_rise;
  assign vs_fall_o    = vs_fall;
  assign de_o         = de_o_q;
  assign pdata_o      = pdata_o_q;
  assign size_err_o   = size_err_q;
  assign line_cnt_o   = line_cnt_q;
  assign last_bytes_o = last_bytes_q;

endmodule

// File: rtl/cmos_capture_ctrl.sv
// Frame-capture sequencer: skips settling frames, arms on request, forwards whole lines of
// whole frames to the packer and reports frame size. de_o/pdata_o lag the sensor by 1 cycle.
// Ports: pclk, rst (async, active-high) and the slave side of cmos_capture_ctrl_if; no
// backpressure, the sensor stream is never stalled, only gated.
module cmos_capture_ctrl
  import cmos_pkg::*;
#(
  parameter int SKIP_FRAMES = DEF_SKIP_FRAMES,
  parameter int EXP_BYTES   = DEF_EXP_BYTES,
  parameter int EXP_LINES   = DEF_EXP_LINES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic              pclk,
  input logic              rst,
  cmos_capture_ctrl_if.slave bus
);

  localparam int SKW  = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);
  localparam int SKW1 = SKW + 1;
  localparam logic [SKW1-1:0] SKIP_TGT = SKW1'(SKIP_FRAMES);

  cap_state_e      state_q, state_d;
  logic [SKW-1:0]  skip_cnt_q, skip_cnt_d;
  logic [SKW1-1:0] skip_nxt;
  logic            frame_start, frame_done, err_clr, cap_en;
  logic            vs_rise, vs_fall;

  // Abort takes effect in the cycle it is presented: nothing is forwarded or measured
  assign cap_en = (state_q == ST_CAPTURE) & ~bus.cap_abort;

  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    err_clr     = 1'b0;
    skip_nxt    = {1'b0, skip_cnt_q} + SKW1'(1);

    if (bus.cap_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cap_start) begin
            err_clr    = 1'b1;
            skip_cnt_d = '0;
            state_d    = (SKIP_FRAMES == 0) ? ST_ARM : ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (vs_rise) begin
            if (skip_nxt >= SKIP_TGT) begin
              state_d = ST_ARM;
            end else begin
              skip_cnt_d = skip_nxt[SKW-1:0];
            end
          end
        end
        ST_ARM: begin
          if (vs_fall) begin
            frame_start = 1'b1;
            state_d     = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (vs_rise) begin
            frame_done = 1'b1;
            state_d    = bus.cap_cont ? ST_ARM : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  cmos_line_meter #(
    .EXP_BYTES (EXP_BYTES),
    .EXP_LINES (EXP_LINES),
    .CNT_W     (CNT_W)
  ) u_meter (
    .pclk         (pclk),
    .rst          (rst),
    .vsync_i      (bus.vsync_i),
    .de_i         (bus.de_i),
    .pdata_i      (bus.pdata_i),
    .cap_en_i     (cap_en),
    .frame_clr_i  (frame_start),
    .err_clr_i    (err_clr),
    .vs_rise_o    (vs_rise),
    .vs_fall_o    (vs_fall),
    .de_o         (bus.de_o),
    .pdata_o      (bus.pdata_o),
    .size_err_o   (bus.size_err),
    .line_cnt_o   (bus.line_cnt),
    .last_bytes_o (bus.last_bytes)
  );

  // Pulses are combinational so they line up with the detecting edge cycle
  assign bus.frame_start = frame_start;
  assign bus.frame_done  = frame_done;
  assign bus.busy        = state_busy(state_q);

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Randomized bench for cmos_capture_ctrl against a frame-level reference model.
// Expected forwarded bytes carry the cycle they must appear on the packer side.
// Ports: none (top-level bench).
module tb_cmos_capture_ctrl;
  import cmos_pkg::*;

  localparam int SKIP  = 2;
  localparam int EXP_B = 8;
  localparam int EXP_L = 4;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  cmos_capture_ctrl_if #(.CNT_W(12)) bus ();

  cmos_capture_ctrl #(
    .SKIP_FRAMES (SKIP),
    .EXP_BYTES   (EXP_B),
    .EXP_LINES   (EXP_L),
    .CNT_W       (12)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$], act_q[$];
  int          fs_exp[$], fs_act[$], fd_exp[$], fd_act[$];

  // Frame-level model of the sequencer
  bit m_active;
  int m_skip_left;
  int m_line_cnt, m_last_bytes;
  bit m_err;

  // Per-frame stimulus knobs
  int f_bad_line, f_bad_len, f_abort_line, f_abort_byte, f_rst_line, f_rst_byte;
  bit f_partial, f_trunc;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (!rst) begin
      if (bus.de_o) begin
        act_q.push_back({cyc[23:0], bus.pdata_o});
        check_val("de_o_while_idle", {31'd0, bus.busy}, 32'd1);
      end
      if (bus.frame_start) fs_act.push_back(cyc);
      if (bus.frame_done)  fd_act.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic clear_knobs();
    f_bad_line = -1; f_bad_len = EXP_B; f_abort_line = -1; f_abort_byte = -1;
    f_rst_line = -1; f_rst_byte = -1; f_partial = 0; f_trunc = 0;
  endtask

  task automatic check_status(input string tag);
    check_val({tag, "_busy"},       {31'd0, bus.busy},     {31'd0, m_active});
    check_val({tag, "_line_cnt"},   {20'd0, bus.line_cnt}, m_line_cnt);
    check_val({tag, "_last_bytes"}, {20'd0, bus.last_bytes}, m_last_bytes);
    check_val({tag, "_size_err"},   {31'd0, bus.size_err}, {31'd0, m_err});
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_de_o"},        {31'd0, bus.de_o}, 0);
    check_val({tag, "_pdata_o"},     {24'd0, bus.pdata_o}, 0);
    check_val({tag, "_frame_start"}, {31'd0, bus.frame_start}, 0);
    check_val({tag, "_frame_done"},  {31'd0, bus.frame_done}, 0);
    check_val({tag, "_busy"},        {31'd0, bus.busy}, 0);
    check_val({tag, "_size_err"},    {31'd0, bus.size_err}, 0);
    check_val({tag, "_line_cnt"},    {20'd0, bus.line_cnt}, 0);
    check_val({tag, "_last_bytes"},  {20'd0, bus.last_bytes}, 0);
  endtask

  task automatic do_start();
    bus.cap_start = 1'b1;
    if (!m_active) begin
      m_active = 1; m_skip_left = SKIP; m_err = 0;
    end
    tick();
    bus.cap_start = 1'b0;
    check_val("start_size_err", {31'd0, bus.size_err}, {31'd0, m_err});
    check_val("start_busy", {31'd0, bus.busy}, 1);
  endtask

  task automatic compare_streams(input string tag);
    int n;
    check_val({tag, "_nbytes"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_val({tag, "_cycle_byte"}, act_q[i], exp_q[i]);
    check_val({tag, "_n_frame_start"}, fs_act.size(), fs_exp.size());
    n = (fs_act.size() < fs_exp.size()) ? fs_act.size() : fs_exp.size();
    for (int i = 0; i < n; i++) check_val({tag, "_frame_start_cyc"}, fs_act[i], fs_exp[i]);
    check_val({tag, "_n_frame_done"}, fd_act.size(), fd_exp.size());
    n = (fd_act.size() < fd_exp.size()) ? fd_act.size() : fd_exp.size();
    for (int i = 0; i < n; i++) check_val({tag, "_frame_done_cyc"}, fd_act[i], fd_exp[i]);
    act_q.delete(); exp_q.delete(); fs_act.delete(); fs_exp.delete(); fd_act.delete(); fd_exp.delete();
  endtask

  // Asynchronous reset in the middle of a forwarded line
  task automatic reset_mid();
    check_val("rst_pre_de_o", {31'd0, bus.de_o}, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    // The byte visible this cycle is wiped by the reset before the monitor samples it
    while (exp_q.size() > 0 && exp_q[$][31:8] == cyc[23:0]) void'(exp_q.pop_back());
    m_active = 0; m_line_cnt = 0; m_last_bytes = 0; m_err = 0;
    #3;
    rst = 1'b0;
  endtask

  task automatic run_frame(input int nlines);
    bit          cap, fwd_on;
    int          closed, len;
    logic [31:0] e;
    cap    = m_active && (m_skip_left == 0);
    fwd_on = cap;
    closed = 0;
    bus.vsync_i = 1'b1; bus.de_i = 1'b0;
    repeat ($urandom_range(2, 5)) tick();
    bus.vsync_i = 1'b0;
    if (cap) fs_exp.push_back(cyc);
    if (f_partial) begin
      for (int i = 0; i < 3; i++) begin
        bus.de_i = 1'b1; bus.pdata_i = 8'($urandom); tick();
      end
    end
    bus.de_i = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
    for (int l = 0; l < nlines; l++) begin
      len = (l == f_bad_line) ? f_bad_len : EXP_B;
      for (int b = 0; b < len; b++) begin
        bus.de_i = 1'b1; bus.pdata_i = 8'($urandom);
        if (l == f_abort_line && b == f_abort_byte) begin
          bus.cap_abort = 1'b1; fwd_on = 0; m_active = 0;
        end
        if (l == f_rst_line && b == f_rst_byte) begin
          reset_mid(); fwd_on = 0;
        end
        if (fwd_on) begin
          e = cyc + 1;
          exp_q.push_back({e[23:0], bus.pdata_i});
        end
        tick();
        if (bus.cap_abort) begin
          bus.cap_abort = 1'b0;
          check_val("abort_busy", {31'd0, bus.busy}, 0);
          check_val("abort_de_o", {31'd0, bus.de_o}, 0);
        end
      end
      if (fwd_on) begin
        closed++; m_last_bytes = len;
        if (len != EXP_B) m_err = 1;
      end
      if (f_trunc && l == nlines - 1) begin
        bus.vsync_i = 1'b1; bus.pdata_i = 8'($urandom);
      end else begin
        bus.de_i = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
      end
    end
    bus.vsync_i = 1'b1;
    if (fwd_on) begin
      fd_exp.push_back(cyc);
      m_line_cnt = closed;
      if (closed != EXP_L) m_err = 1;
      m_active = bus.cap_cont;
    end else if (m_active && !cap) begin
      m_skip_left--;
    end
    tick();
    bus.de_i = 1'b0;
    tick();
    check_status("frame_end");
  endtask

  initial begin
    bus.vsync_i = 1'b1; bus.de_i = 1'b0; bus.pdata_i = '0;
    bus.cap_start = 1'b0; bus.cap_cont = 1'b0; bus.cap_abort = 1'b0;
    m_active = 0; m_skip_left = 0; m_line_cnt = 0; m_last_bytes = 0; m_err = 0;
    clear_knobs();
    repeat (3) @(posedge pclk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) tick();

    // Single shot: two skipped frames, one captured, then idle
    do_start();
    repeat (4) run_frame(EXP_L);
    compare_streams("single");

    // Continuous: ignored restart while skipping, three captures, drop cap_cont before the last
    bus.cap_cont = 1'b1;
    do_start();
    run_frame(EXP_L);
    do_start();
    run_frame(EXP_L);
    run_frame(EXP_L);
    run_frame(EXP_L);
    bus.cap_cont = 1'b0;
    run_frame(EXP_L);
    run_frame(EXP_L);
    compare_streams("continuous");

    // Short last line flags a mismatch; the next start clears it
    do_start();
    repeat (2) run_frame(EXP_L);
    f_bad_line = EXP_L - 1; f_bad_len = 6;
    run_frame(EXP_L);
    clear_knobs();
    compare_streams("mismatch");

    // Arm while a line is already running: that line is dropped
    do_start();
    repeat (2) run_frame(EXP_L);
    f_partial = 1;
    run_frame(EXP_L);
    clear_knobs();
    compare_streams("mid_line_arm");

    // Last of five lines cut short by vsync rising
    do_start();
    repeat (2) run_frame(EXP_L);
    f_trunc = 1; f_bad_line = 4; f_bad_len = $urandom_range(2, 7);
    run_frame(5);
    clear_knobs();
    compare_streams("truncated");

    // Abort at byte 3 of line 2
    do_start();
    repeat (2) run_frame(EXP_L);
    f_abort_line = 1; f_abort_byte = 2;
    run_frame(EXP_L);
    clear_knobs();
    compare_streams("abort");

    // Reset during a forwarded line, then a full fresh sequence
    do_start();
    repeat (2) run_frame(EXP_L);
    f_rst_line = 1; f_rst_byte = 4;
    run_frame(EXP_L);
    clear_knobs();
    do_start();
    repeat (3) run_frame(EXP_L);
    compare_streams("reset_mid");

    // Random mix of line counts, bad lines and continuous/single mode
    for (int f = 0; f < 10; f++) begin
      bus.cap_cont = 1'($urandom_range(0, 1));
      if (!m_active) do_start();
      if ($urandom_range(0, 2) == 0) begin
        f_bad_line = $urandom_range(0, 3); f_bad_len = $urandom_range(3, 10);
      end
      run_frame($urandom_range(3, 5));
      clear_knobs();
    end
    compare_streams("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
